// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard/forwarding controller: two-source operand forwarding, load-use
// and branch-in-ID stall detection, debug halt/drain FSM and saturating perf counters.
module id_hazard_ctrl #(
  parameter int NB_ADDR      = 5,
  parameter int NB_CNT       = 16,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NB_ADDR-1:0] i_rs_id,
  input  logic [NB_ADDR-1:0] i_rt_id,
  input  logic               i_uses_rt_id,
  input  logic               i_branch_id,
  input  logic               i_branch_taken_id,
  input  logic [NB_ADDR-1:0] i_rd_ex,
  input  logic               i_regWrite_ex,
  input  logic               i_memRead_ex,
  input  logic [NB_ADDR-1:0] i_rd_ex_m,
  input  logic               i_regWrite_ex_m,
  input  logic               i_memRead_ex_m,
  input  logic [NB_ADDR-1:0] i_rd_m_wb,
  input  logic               i_regWrite_m_wb,
  input  logic               i_halt,
  input  logic               i_cnt_clr,
  output logic [1:0]         o_forwardA_ID,
  output logic [1:0]         o_forwardB_ID,
  output logic               o_stall,
  output logic               o_bubble_ex,
  output logic               o_flush_if,
  output logic               o_halted,
  output logic [NB_CNT-1:0]  o_stall_cnt,
  output logic [NB_CNT-1:0]  o_flush_cnt,
  output logic [1:0]         o_dbg_state
);

  localparam int NB_DRN = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t              state;
  logic [NB_DRN-1:0]   drain_cnt;
  logic                hazard;
  logic                match_ex;
  logic                match_ex_m;

  // EX/MEM holds the younger result, so it wins over MEM/WB; r0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [NB_ADDR-1:0] src);
    if (i_regWrite_ex_m && (i_rd_ex_m != '0) && (i_rd_ex_m == src))
      return 2'b01;
    else if (i_regWrite_m_wb && (i_rd_m_wb != '0) && (i_rd_m_wb == src))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  function automatic logic src_match(input logic [NB_ADDR-1:0] rd);
    return (rd != '0) && ((rd == i_rs_id) || (i_uses_rt_id && (rd == i_rt_id)));
  endfunction

  always_comb begin
    o_forwardA_ID = fwd_sel(i_rs_id);
    o_forwardB_ID = fwd_sel(i_rt_id);
  end

  always_comb begin
    match_ex   = src_match(i_rd_ex);
    match_ex_m = src_match(i_rd_ex_m);
    hazard     = (i_memRead_ex && i_regWrite_ex && match_ex)
               | (i_branch_id  && i_regWrite_ex && match_ex)
               | (i_branch_id  && i_memRead_ex_m && match_ex_m);
  end

  always_comb begin
    o_stall     = 1'b1;
    o_bubble_ex = 1'b1;
    o_flush_if  = 1'b0;
    o_halted    = 1'b0;
    case (state)
      RUN: begin
        o_stall     = hazard;
        o_bubble_ex = hazard;
        o_flush_if  = i_branch_taken_id && !hazard;
      end
      HALTED:  o_halted = 1'b1;
      default: ;
    endcase
  end

  assign o_dbg_state = state;

  // Once draining starts it always runs to completion, even if the request drops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      case (state)
        RUN: if (i_halt) begin
          state     <= DRAIN;
          drain_cnt <= NB_DRN'(DRAIN_CYCLES - 1);
        end
        DRAIN: begin
          if (drain_cnt == '0) state <= HALTED;
          else                 drain_cnt <= drain_cnt - 1'b1;
        end
        HALTED: if (!i_halt) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else if (i_cnt_clr) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if ((state == RUN) && hazard && (o_stall_cnt != '1))
        o_stall_cnt <= o_stall_cnt + 1'b1;
      if (o_flush_if && (o_flush_cnt != '1))
        o_flush_cnt <= o_flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: directed test-plan steps then random traffic, all
// compared each cycle against a rule-level reference model (16-bit and 2-bit counter instances).
module tb_id_hazard_ctrl;

  localparam int DRAIN = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs, rt, rd_ex, rd_exm, rd_mwb;
  logic       uses_rt, br, taken, wr_ex, mr_ex, wr_exm, mr_exm, wr_mwb, halt, clr;

  logic [1:0]  fa, fb, fa2, fb2, dbg, dbg2;
  logic        stall, bub, flush, halted, stall2, bub2, flush2, halted2;
  logic [15:0] scnt, fcnt;
  logic [1:0]  scnt2, fcnt2;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int     m_mode;   // 0 running, 1 draining, 2 halted
  int     m_left;
  longint m_s16, m_f16, m_s2, m_f2;

  id_hazard_ctrl #(.NB_ADDR(5), .NB_CNT(16), .DRAIN_CYCLES(DRAIN)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rs_id(rs), .i_rt_id(rt), .i_uses_rt_id(uses_rt),
    .i_branch_id(br), .i_branch_taken_id(taken), .i_rd_ex(rd_ex), .i_regWrite_ex(wr_ex),
    .i_memRead_ex(mr_ex), .i_rd_ex_m(rd_exm), .i_regWrite_ex_m(wr_exm),
    .i_memRead_ex_m(mr_exm), .i_rd_m_wb(rd_mwb), .i_regWrite_m_wb(wr_mwb),
    .i_halt(halt), .i_cnt_clr(clr), .o_forwardA_ID(fa), .o_forwardB_ID(fb),
    .o_stall(stall), .o_bubble_ex(bub), .o_flush_if(flush), .o_halted(halted),
    .o_stall_cnt(scnt), .o_flush_cnt(fcnt), .o_dbg_state(dbg)
  );

  id_hazard_ctrl #(.NB_ADDR(5), .NB_CNT(2), .DRAIN_CYCLES(DRAIN)) dut_small (
    .i_clk(clk), .i_rst_n(rst_n), .i_rs_id(rs), .i_rt_id(rt), .i_uses_rt_id(uses_rt),
    .i_branch_id(br), .i_branch_taken_id(taken), .i_rd_ex(rd_ex), .i_regWrite_ex(wr_ex),
    .i_memRead_ex(mr_ex), .i_rd_ex_m(rd_exm), .i_regWrite_ex_m(wr_exm),
    .i_memRead_ex_m(mr_exm), .i_rd_m_wb(rd_mwb), .i_regWrite_m_wb(wr_mwb),
    .i_halt(halt), .i_cnt_clr(clr), .o_forwardA_ID(fa2), .o_forwardB_ID(fb2),
    .o_stall(stall2), .o_bubble_ex(bub2), .o_flush_if(flush2), .o_halted(halted2),
    .o_stall_cnt(scnt2), .o_flush_cnt(fcnt2), .o_dbg_state(dbg2)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit reads(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    return (r == rs) || (uses_rt && (r == rt));
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] r);
    if (r == 5'd0)                   return 2'd0;
    if (wr_exm && (rd_exm == r))     return 2'd1;
    if (wr_mwb && (rd_mwb == r))     return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit m_hazard();
    bit load_use, br_alu, br_load;
    load_use = mr_ex && wr_ex && reads(rd_ex);
    br_alu   = br && wr_ex && reads(rd_ex);
    br_load  = br && mr_exm && reads(rd_exm);
    return load_use || br_alu || br_load;
  endfunction

  function automatic logic [7:0] m_outputs();
    bit hz, st, fl, hl;
    hz = m_hazard();
    st = (m_mode == 0) ? hz : 1'b1;
    fl = (m_mode == 0) && taken && !hz;
    hl = (m_mode == 2);
    return {m_fwd(rs), m_fwd(rt), st, st, fl, hl};
  endfunction

  function automatic longint sat_inc(input longint v, input longint max);
    return (v < max) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_left = 0;
    m_s16 = 0; m_f16 = 0; m_s2 = 0; m_f2 = 0;
  endtask

  task automatic model_edge();
    bit hz, fl;
    hz = m_hazard();
    fl = (m_mode == 0) && taken && !hz;
    if (clr) begin
      m_s16 = 0; m_f16 = 0; m_s2 = 0; m_f2 = 0;
    end else begin
      if (m_mode == 0 && hz) begin
        m_s16 = sat_inc(m_s16, 65535); m_s2 = sat_inc(m_s2, 3);
      end
      if (fl) begin
        m_f16 = sat_inc(m_f16, 65535); m_f2 = sat_inc(m_f2, 3);
      end
    end
    case (m_mode)
      0: if (halt) begin m_mode = 1; m_left = DRAIN; end
      1: begin m_left--; if (m_left == 0) m_mode = 2; end
      default: if (!halt) m_mode = 0;
    endcase
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle(input string tag);
    logic [7:0] e;
    exp_q.push_back(m_outputs());
    e = exp_q.pop_front();
    chk({tag, ".outs"},  {24'd0, fa, fb, stall, bub, flush, halted}, {24'd0, e});
    chk({tag, ".outs2"}, {24'd0, fa2, fb2, stall2, bub2, flush2, halted2}, {24'd0, e});
    chk({tag, ".scnt"},  {16'd0, scnt}, 32'(m_s16));
    chk({tag, ".fcnt"},  {16'd0, fcnt}, 32'(m_f16));
    chk({tag, ".scnt2"}, {30'd0, scnt2}, 32'(m_s2));
    chk({tag, ".fcnt2"}, {30'd0, fcnt2}, 32'(m_f2));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    rs = 0; rt = 0; uses_rt = 0; br = 0; taken = 0;
    rd_ex = 0; wr_ex = 0; mr_ex = 0; rd_exm = 0; wr_exm = 0; mr_exm = 0;
    rd_mwb = 0; wr_mwb = 0; halt = 0; clr = 0;
  endtask

  // called at posedge+1: settle, check, clock edge, advance model
  task automatic cyc(input string tag);
    #1;
    check_cycle(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic randomize_inputs();
    rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7));
    rd_ex = 5'($urandom_range(0, 7)); rd_exm = 5'($urandom_range(0, 7));
    rd_mwb = 5'($urandom_range(0, 7));
    uses_rt = 1'($urandom); br = 1'($urandom); taken = 1'($urandom);
    wr_ex = 1'($urandom); mr_ex = 1'($urandom); wr_exm = 1'($urandom);
    mr_exm = 1'($urandom); wr_mwb = 1'($urandom);
    if ($urandom_range(0, 15) == 0) halt = ~halt;
    clr = ($urandom_range(0, 31) == 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    #3;
    check_cycle("reset");
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // forwarding priority and r0
    rs = 3; rt = 3; uses_rt = 1; rd_exm = 3; wr_exm = 1; rd_mwb = 3; wr_mwb = 1;
    #1 chk("fwd_exm_A", {30'd0, fa}, 32'd1);
    chk("fwd_exm_B", {30'd0, fb}, 32'd1);
    cyc("fwd_exm");
    wr_exm = 0;
    #1 chk("fwd_mwb_A", {30'd0, fa}, 32'd2);
    cyc("fwd_mwb");
    wr_exm = 1; rd_exm = 0; rd_mwb = 0; rd_ex = 0; wr_ex = 1; rs = 0; rt = 0;
    #1 chk("fwd_r0_A", {30'd0, fa}, 32'd0);
    cyc("fwd_r0");

    // load-use
    idle(); rd_ex = 5; mr_ex = 1; wr_ex = 1; rs = 5;
    #1 chk("lu_stall", {31'd0, stall}, 32'd1);
    cyc("lu");
    rs = 0; rt = 5; uses_rt = 0;
    #1 chk("lu_cnt", {16'd0, scnt}, 32'd1);
    chk("lu_nort", {31'd0, stall}, 32'd0);
    cyc("lu_nort");

    // branch after load: two stall cycles, then MEM/WB forward and a flush
    idle(); clr = 1; cyc("clr1");
    idle(); br = 1; rs = 7; rd_ex = 7; mr_ex = 1; wr_ex = 1;
    cyc("bl_1");
    rd_ex = 0; mr_ex = 0; wr_ex = 0; rd_exm = 7; mr_exm = 1; wr_exm = 1;
    #1 chk("bl_2_stall", {31'd0, stall}, 32'd1);
    cyc("bl_2");
    rd_exm = 0; mr_exm = 0; wr_exm = 0; rd_mwb = 7; wr_mwb = 1;
    #1 chk("bl_fwd", {30'd0, fa}, 32'd2);
    chk("bl_cnt", {16'd0, scnt}, 32'd2);
    cyc("bl_3");
    taken = 1;
    #1 chk("bl_flush", {31'd0, flush}, 32'd1);
    cyc("bl_taken");
    idle();
    #1 chk("bl_fcnt", {16'd0, fcnt}, 32'd1);
    cyc("bl_after");

    // halt / drain with hazards and taken branches present (must not count)
    halt = 1; cyc("halt_req");
    halt = 0; taken = 1; rd_ex = 4; rs = 4; mr_ex = 1; wr_ex = 1;
    for (int i = 0; i < DRAIN; i++) begin
      #1 chk("drain_halted", {31'd0, halted}, 32'd0);
      chk("drain_stall", {31'd0, stall}, 32'd1);
      cyc("drain");
    end
    halt = 1;
    #1 chk("halted", {31'd0, halted}, 32'd1);
    cyc("halted_hold");
    halt = 0; cyc("halted_rel");
    idle();
    #1 chk("halt_back_run", {31'd0, halted}, 32'd0);
    chk("halt_cnt", {16'd0, scnt}, 32'd2);
    cyc("run_again");

    // saturation and clear priority on the 2-bit instance
    clr = 1; cyc("clr2");
    idle(); rd_ex = 5; mr_ex = 1; wr_ex = 1; rs = 5;
    for (int i = 0; i < 5; i++) cyc("sat");
    #1 chk("sat_val", {30'd0, scnt2}, 32'd3);
    clr = 1; cyc("clr_hz");
    clr = 0;
    #1 chk("clr_prio", {30'd0, scnt2}, 32'd0);
    cyc("after_clr");

    // async reset in the middle of a drain
    idle(); halt = 1; cyc("rst_halt");
    halt = 0; cyc("rst_drain");
    #1 rst_n = 1'b0;
    model_reset();
    #1 chk("arst_halted", {31'd0, halted}, 32'd0);
    chk("arst_stall", {31'd0, stall}, 32'd0);
    check_cycle("arst");
    #1 rst_n = 1'b1;
    cyc("arst_rel");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      cyc("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
- Hazard and forwarding controller for the ID stage of the 5-stage MIPS pipeline.
- Generalises the single-source ID forwarding unit in three ways: two forward sources (EX/MEM and MEM/WB); r0 exclusion; load-use and branch-in-ID stall detection.
- Adds a halt/drain FSM used by the debug unit to freeze fetch and empty the pipeline.
- Adds saturating stall/flush performance counters.

Parameters:
- NB_ADDR, 5, register address width.
- NB_CNT, 16, width of each performance counter.
- DRAIN_CYCLES, 4, bubble cycles inserted before halt is reported (covers ID through WB).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_rs_id  in  NB_ADDR  rs of the instruction in ID.
- i_rt_id  in  NB_ADDR  rt of the instruction in ID.
- i_uses_rt_id  in  1  ID instruction reads rt.
- i_branch_id  in  1  ID instruction resolves a branch/jr in ID and needs its operands now.
- i_branch_taken_id  in  1  branch in ID is taken this cycle.
- i_rd_ex  in  NB_ADDR  destination register in EX.
- i_regWrite_ex  in  1  EX instruction writes the register file.
- i_memRead_ex  in  1  EX instruction is a load.
- i_rd_ex_m  in  NB_ADDR  destination register in EX/MEM.
- i_regWrite_ex_m  in  1  EX/MEM instruction writes the register file.
- i_memRead_ex_m  in  1  EX/MEM instruction is a load.
- i_rd_m_wb  in  NB_ADDR  destination register in MEM/WB.
- i_regWrite_m_wb  in  1  MEM/WB instruction writes the register file.
- i_halt  in  1  debug halt request, level.
- i_cnt_clr  in  1  synchronous clear of both counters.
- o_forwardA_ID  out  2  rs select: 00 RF, 01 EX/MEM, 10 MEM/WB.
- o_forwardB_ID  out  2  rt select, same encoding.
- o_stall  out  1  hold PC and IF/ID.
- o_bubble_ex  out  1  zero ID/EX control signals.
- o_flush_if  out  1  squash IF/ID.
- o_halted  out  1  pipeline drained and frozen.
- o_stall_cnt  out  NB_CNT  hazard stall cycles.
- o_flush_cnt  out  NB_CNT  flushes issued.

Behaviour:
- Forwarding (combinational, rs shown; rt identical using i_rt_id):
  - 01 if i_regWrite_ex_m && i_rd_ex_m!=0 && i_rd_ex_m==i_rs_id.
  - else 10 if i_regWrite_m_wb && i_rd_m_wb!=0 && i_rd_m_wb==i_rs_id.
  - else 00.
  - EX/MEM always wins over MEM/WB. Forwarding is active in every FSM state.
- Match term, per stage X: rd_X!=0 && (rd_X==rs || (i_uses_rt_id && rd_X==rt)).
- hazard (combinational) is set by any of:
  - Load-use: i_memRead_ex && i_regWrite_ex && match(EX).
  - Branch vs ALU op in EX: i_branch_id && i_regWrite_ex && match(EX).
  - Branch vs load in MEM: i_branch_id && i_memRead_ex_m && match(EX/MEM).
  - Consequence: a load followed by a dependent branch stalls 2 cycles; an ALU op followed by a dependent branch stalls 1 cycle.
- FSM states RUN, DRAIN, HALTED; reset state RUN.
  - RUN: o_stall=o_bubble_ex=hazard. o_flush_if=i_branch_taken_id && !hazard. On i_halt -> DRAIN, and the drain counter loads DRAIN_CYCLES-1.
  - DRAIN: o_stall=1, o_bubble_ex=1, o_flush_if=0. Counter decrements each cycle; at 0 -> HALTED. Deasserting i_halt in DRAIN does not abort; the drain completes.
  - HALTED: o_stall=1, o_bubble_ex=1, o_flush_if=0, o_halted=1. If !i_halt -> RUN next cycle.
- Outputs are combinational from state and inputs. o_halted is a Moore output (HALTED only).
- The ID instruction is held through DRAIN/HALTED and is re-evaluated for hazards on return to RUN.
- Counters:
  - o_stall_cnt +1 each RUN cycle with hazard.
  - o_flush_cnt +1 each cycle o_flush_if=1.
  - Both saturate at all-ones.
  - i_cnt_clr has priority over an increment in the same cycle (result 0).
  - Neither counter counts in DRAIN/HALTED.
- Reset (async, any time including mid-DRAIN): state RUN, drain counter 0, both counters 0, o_halted 0. Remaining outputs follow the combinational RUN equations.

Test Plan:
- Forwarding priority and r0: rs=rt=3; EX/MEM rd=3 wr=1; MEM/WB rd=3 wr=1 -> A=B=01. Drop EX/MEM wr -> A=B=10. Set every rd=0 with all wr=1 -> A=B=00.
- Load-use: EX load rd=5 (memRead=1, wr=1); ID rs=5 -> stall=1, bubble=1, o_stall_cnt 0->1. Same case with ID rt=5 and uses_rt=0 -> no stall.
- Branch after load: ID branch rs=7; EX load rd=7 -> stall cycle 1. Load advances to EX/MEM (memRead_ex_m=1) -> stall cycle 2. Next cycle forwardA=10 with no stall -> o_stall_cnt=2. Taken branch then gives flush_if=1 and o_flush_cnt=1.
- Halt, DRAIN_CYCLES=4: pulse i_halt 1 cycle in RUN -> stall/bubble high 4 cycles, o_halted=0. Then HALTED with o_halted=1 while i_halt high. Drop i_halt -> RUN next cycle. Counters unchanged throughout.
- Saturation/clear, NB_CNT=2: hold a hazard for 5 cycles -> o_stall_cnt=3. Assert i_cnt_clr together with a hazard -> 0.
- Async reset: assert i_rst_n=0 mid-DRAIN between clock edges -> immediately state RUN, o_halted=0, counters=0.
